// File: rtl/accu_rr_sched_if.sv
// accu_rr_sched_if: request/sample/result bundle between channel sources and the shared accumulator scheduler
interface accu_rr_sched_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  logic                   en;
  logic [N-1:0]           req;
  logic [N*DW-1:0]        d;
  logic [N-1:0]           clr;
  logic [N-1:0]           gnt;
  logic                   out_vld;
  logic [$clog2(N)-1:0]   out_ch;
  logic [DW-1:0]          out_acc;
  logic [N*DW-1:0]        acc_all;
  modport master (output en, req, d, clr, input gnt, out_vld, out_ch, out_acc, acc_all);
  modport slave  (input en, req, d, clr, output gnt, out_vld, out_ch, out_acc, acc_all);
endinterface

// File: rtl/accu_rr_sched.sv
// accu_rr_sched: round-robin sharing of one modulo-M adder across N per-channel accumulators
module accu_rr_sched #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int M  = 0
) (
  input  logic            clk,
  input  logic            rst,
  accu_rr_sched_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [DW:0] MV = (DW+1)'(M);
  logic [CW-1:0] ptr, idx;
  logic          found;
  logic [DW-1:0] acc [N];
  logic [DW-1:0] dsel, base, nv;
  logic [DW:0]   sum, red;
  always_comb begin
    found   = 1'b0;
    idx     = ptr;
    bus.gnt = '0;
    for (int k = 0; k < N; k++)
      if (!found && bus.en && bus.req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = CW'((int'(ptr) + k) % N);
        bus.gnt[(int'(ptr) + k) % N] = 1'b1;
      end
    dsel = bus.d[int'(idx)*DW +: DW];
    base = bus.clr[idx] ? '0 : acc[idx];
    sum  = {1'b0, base} + {1'b0, dsel};
    red  = (M != 0 && sum >= MV) ? sum - MV : sum;
    nv   = red[DW-1:0];
  end
  always_ff @(posedge clk)
    if (rst) begin
      ptr         <= '0;
      bus.out_vld <= 1'b0;
      bus.out_ch  <= '0;
      bus.out_acc <= '0;
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else begin
      bus.out_vld <= found;
      for (int i = 0; i < N; i++) if (bus.clr[i]) acc[i] <= '0;
      if (found) begin
        acc[idx]    <= nv;
        ptr         <= (int'(idx) == N-1) ? '0 : idx + 1'b1;
        bus.out_ch  <= idx;
        bus.out_acc <= nv;
      end
    end
  for (genvar g = 0; g < N; g++) begin : g_all
    assign bus.acc_all[g*DW +: DW] = acc[g];
  end
endmodule
